// File: rtl/data_mem_arbiter_if.sv
// Requester / memory bundle between two data-side requesters, the arbiter and the memory.
// Pure wiring, no latency of its own.
// Handshake is request-held-until-grant; the memory side has no backpressure.
interface data_mem_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  // requester 0
  logic              i_req0;
  logic              i_we0;
  logic [ADDR_W-1:0] i_addr0;
  logic [DATA_W-1:0] i_wdata0;
  logic              o_gnt0;
  logic              o_rvalid0;
  logic [DATA_W-1:0] o_rdata0;
  // requester 1
  logic              i_req1;
  logic              i_we1;
  logic [ADDR_W-1:0] i_addr1;
  logic [DATA_W-1:0] i_wdata1;
  logic              o_gnt1;
  logic              o_rvalid1;
  logic [DATA_W-1:0] o_rdata1;
  // memory port
  logic              o_mem_MemRead;
  logic              o_mem_MemWrite;
  logic [ADDR_W-1:0] o_mem_r_addr;
  logic [ADDR_W-1:0] o_mem_w_addr;
  logic [DATA_W-1:0] o_mem_data;
  logic              i_mem_valid;
  logic [DATA_W-1:0] i_mem_data;

  // arbiter side
  modport slave (
    input  i_req0, i_we0, i_addr0, i_wdata0,
    input  i_req1, i_we1, i_addr1, i_wdata1,
    input  i_mem_valid, i_mem_data,
    output o_gnt0, o_rvalid0, o_rdata0,
    output o_gnt1, o_rvalid1, o_rdata1,
    output o_mem_MemRead, o_mem_MemWrite, o_mem_r_addr, o_mem_w_addr, o_mem_data
  );

  // requesters + memory side (environment)
  modport master (
    output i_req0, i_we0, i_addr0, i_wdata0,
    output i_req1, i_we1, i_addr1, i_wdata1,
    output i_mem_valid, i_mem_data,
    input  o_gnt0, o_rvalid0, o_rdata0,
    input  o_gnt1, o_rvalid1, o_rdata1,
    input  o_mem_MemRead, o_mem_MemWrite, o_mem_r_addr, o_mem_w_addr, o_mem_data
  );
endinterface

// File: rtl/data_mem_arbiter.sv
// Two-requester arbiter onto one data memory port; ARB_FIXED_PRIO_EN selects fixed priority (req0 wins).
// Grant and memory strobes are combinational in IDLE; read data returns 2 cycles after grant.
// Writes may issue every cycle; a read blocks further grants for RD1/RD2 (one read per 3 cycles).
module data_mem_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  data_mem_arbiter_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD1  = 2'd1,
    RD2  = 2'd2
  } state_t;

  state_t r_state;
  logic   r_owner;     // requester whose read is in flight
`ifndef ARB_FIXED_PRIO_EN
  logic   r_ptr;       // preferred requester on a tie
`endif

  logic              w_any_req;
  logic              w_grant;     // a grant is issued this cycle
  logic              w_sel;       // granted requester index
  logic              w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic              w_mem_wr;
  logic              w_mem_rd;
  logic              w_rd_ret;    // memory data returning for the owner

  // Winner selection: a lone requester always wins; ties go to the pointer (or req0 when fixed).
  always_comb begin
    w_sel = 1'b0;
    if (bus.i_req0 && bus.i_req1) begin
`ifdef ARB_FIXED_PRIO_EN
      w_sel = 1'b0;
`else
      w_sel = r_ptr;
`endif
    end else if (bus.i_req1) begin
      w_sel = 1'b1;
    end
  end

  // Gate with reset so every output reads 0 the moment reset asserts, even with requests pending.
  assign w_any_req = bus.i_req0 | bus.i_req1;
  assign w_grant   = i_rst_n & (r_state == IDLE) & w_any_req;

  assign w_we    = w_sel ? bus.i_we1    : bus.i_we0;
  assign w_addr  = w_sel ? bus.i_addr1  : bus.i_addr0;
  assign w_wdata = w_sel ? bus.i_wdata1 : bus.i_wdata0;

  assign w_mem_wr = w_grant &  w_we;
  assign w_mem_rd = w_grant & ~w_we;

  assign bus.o_gnt0 = w_grant & ~w_sel;
  assign bus.o_gnt1 = w_grant &  w_sel;

  // Address/data buses are held at 0 when their strobe is low.
  assign bus.o_mem_MemWrite = w_mem_wr;
  assign bus.o_mem_MemRead  = w_mem_rd;
  assign bus.o_mem_w_addr   = w_mem_wr ? w_addr  : '0;
  assign bus.o_mem_data     = w_mem_wr ? w_wdata : '0;
  assign bus.o_mem_r_addr   = w_mem_rd ? w_addr  : '0;

  // Memory valid is only honoured in RD2; anything else on i_mem_valid is ignored.
  assign w_rd_ret      = i_rst_n & (r_state == RD2) & bus.i_mem_valid;
  assign bus.o_rvalid0 = w_rd_ret & ~r_owner;
  assign bus.o_rvalid1 = w_rd_ret &  r_owner;
  assign bus.o_rdata0  = bus.o_rvalid0 ? bus.i_mem_data : '0;
  assign bus.o_rdata1  = bus.o_rvalid1 ? bus.i_mem_data : '0;

  // FSM: reads walk IDLE->RD1->RD2->IDLE; writes keep it in IDLE; pointer toggles on every grant.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_owner <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
      r_ptr   <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant) begin
`ifndef ARB_FIXED_PRIO_EN
            r_ptr <= ~r_ptr;
`endif
            if (!w_we) begin
              r_owner <= w_sel;
              r_state <= RD1;
            end
          end
        end
        RD1:     r_state <= RD2;
        RD2:     r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
